// File: rtl/fib_index.sv
// rtl/fib_index.sv - Fibonacci index search: classifies a 32-bit value and reports its index (optional FIB_INDEX_PREV_EN adds prev_fib)
module fib_index (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        is_fib,
  output logic [5:0]  n
`ifdef FIB_INDEX_PREV_EN
  ,
  output logic [31:0] prev_fib
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [5:0] K_LAST   = 6'd47;
  localparam logic [5:0] K_OUTRNG = 6'd48;

  state_t      state, state_nxt;
  logic [31:0] target, target_nxt;
  logic [31:0] a, a_nxt;
  logic [32:0] b, b_nxt;
  logic [5:0]  k, k_nxt;
  logic        is_fib_nxt;
  logic [5:0]  n_nxt;

  // Termination conditions, in priority order: match, overshoot, index exhausted
  logic hit_eq, hit_gt, hit_end;
  assign hit_eq  = (a == target);
  assign hit_gt  = (a > target);
  assign hit_end = (k == K_LAST);

  // Status flags are pure decodes of the state register
  assign busy = (state == SEARCH);
  assign done = (state == DONE);

  // Next-state and datapath update: accept a query, or advance/terminate the search
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    a_nxt      = a;
    b_nxt      = b;
    k_nxt      = k;
    is_fib_nxt = is_fib;
    n_nxt      = n;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          target_nxt = value;
          a_nxt      = 32'd0;
          b_nxt      = 33'd1;
          k_nxt      = 6'd0;
          state_nxt  = SEARCH;
        end
      end
      SEARCH: begin
        if (hit_eq) begin
          is_fib_nxt = 1'b1;
          n_nxt      = k;
          state_nxt  = DONE;
        end else if (hit_gt) begin
          is_fib_nxt = 1'b0;
          n_nxt      = k;
          state_nxt  = DONE;
        end else if (hit_end) begin
          // a = F(47) is still below target: nothing representable matches
          is_fib_nxt = 1'b0;
          n_nxt      = K_OUTRNG;
          state_nxt  = DONE;
        end else begin
          // b may carry into bit 32 only after k=46; that value is never moved into a
          a_nxt = b[31:0];
          b_nxt = {1'b0, a} + b;
          k_nxt = k + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      target <= 32'd0;
      a      <= 32'd0;
      b      <= 33'd1;
      k      <= 6'd0;
      is_fib <= 1'b0;
      n      <= 6'd0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      k      <= k_nxt;
      is_fib <= is_fib_nxt;
      n      <= n_nxt;
    end
  end

`ifdef FIB_INDEX_PREV_EN
  logic [31:0] prev_nxt;
  logic [31:0] b_lo;
  assign b_lo = b[31:0];

  // Largest Fibonacci number not above the query; F(k-1) = F(k+1) - F(k) holds modulo 2^32
  always_comb begin
    prev_nxt = prev_fib;
    if (state == SEARCH) begin
      if (hit_eq) begin
        prev_nxt = target;
      end else if (hit_gt) begin
        prev_nxt = b_lo - a;
      end else if (hit_end) begin
        prev_nxt = a;
      end
    end
  end

  // prev_fib register, loaded on entry to DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_fib <= 32'd0;
    end else begin
      prev_fib <= prev_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fib_index.sv
// tb/tb_fib_index.sv - directed self-checking bench for fib_index
module tb_fib_index;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        is_fib;
  logic [5:0]  n;
`ifdef FIB_INDEX_PREV_EN
  logic [31:0] prev_fib;
`endif

  int checks = 0;
  int errors = 0;

  fib_index dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .is_fib  (is_fib),
    .n       (n)
`ifdef FIB_INDEX_PREV_EN
    ,
    .prev_fib(prev_fib)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one query and follow it to done; optionally keep start high and change value mid-search
  task automatic run_query(input string tag, input logic [31:0] v, input logic exp_fib,
                           input logic [5:0] exp_n, input int exp_lat,
                           input logic [31:0] exp_prev, input logic hold);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    check({tag, ".e0_busy"}, 64'(busy), 64'd1);
    check({tag, ".e0_done"}, 64'(done), 64'd0);
    if (hold) value = 32'd5;
    else      start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".is_fib"}, 64'(is_fib), 64'(exp_fib));
    check({tag, ".n"}, 64'(n), 64'(exp_n));
`ifdef FIB_INDEX_PREV_EN
    check({tag, ".prev_fib"}, 64'(prev_fib), 64'(exp_prev));
`else
    if (exp_prev == 32'hDEAD_BEEF) $display("note: unused sentinel");
`endif
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    value = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.is_fib", 64'(is_fib), 64'd0);
    check("rst.n", 64'(n), 64'd0);
`ifdef FIB_INDEX_PREV_EN
    check("rst.prev_fib", 64'(prev_fib), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    run_query("v0",      32'd0,          1'b1, 6'd0,  1,  32'd0,          1'b0);
    run_query("v1",      32'd1,          1'b1, 6'd1,  2,  32'd1,          1'b0);
    run_query("v832040", 32'd832040,     1'b1, 6'd30, 31, 32'd832040,     1'b0);
    run_query("v100",    32'd100,        1'b0, 6'd12, 13, 32'd89,         1'b0);
    run_query("vF47",    32'd2971215073, 1'b1, 6'd47, 48, 32'd2971215073, 1'b0);
    run_query("vmax",    32'hFFFF_FFFF,  1'b0, 6'd48, 48, 32'd2971215073, 1'b0);
    run_query("v4",      32'd4,          1'b0, 6'd5,  6,  32'd3,          1'b0);
    run_query("hold",    32'd832040,     1'b1, 6'd30, 31, 32'd832040,     1'b1);

    // Reset in the middle of a search: k reaches 10 after the tenth edge past E0
    @(negedge clk);
    start = 1'b1;
    value = 32'd832040;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid.busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid.busy", 64'(busy), 64'd0);
    check("mid.done", 64'(done), 64'd0);
    check("mid.n", 64'(n), 64'd0);
    check("mid.is_fib", 64'(is_fib), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_query("v5", 32'd5, 1'b1, 6'd5, 6, 32'd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fib_index.md
# fib_index

Inverse of the Fibonacci generator: accepts a 32-bit value and searches the Fibonacci sequence iteratively, one term per clock. It reports whether the value is a Fibonacci number and its index n, where F(0)=0, F(1)=1 and F(k+1)=F(k)+F(k-1). It sits beside the generator on the same start/done control bus, so generator output can be round-trip checked and host-supplied values can be classified.

## Interface
- No parameters. The datapath is fixed at 32 bits and the largest representable index is F(47)=2971215073.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset. It is sampled on the rising edge of clk.
- start  input  1  request pulse or level. Sampled only in IDLE and DONE.
- value  input  32  query operand, latched on the edge that accepts start.
- busy  output  1  high while in SEARCH.
- done  output  1  high while in DONE; results are valid.
- is_fib  output  1  value equals some F(k).
- n  output  6  result index (see Operation).
- prev_fib  output  32  present only with FIB_INDEX_PREV_EN.

## Operation
- States: IDLE, SEARCH, DONE.
- Registers:
  - target[31:0]: latched query.
  - a[31:0]: F(k).
  - b[32:0]: F(k+1), one extra bit for overflow.
  - k[5:0]: current index.
- IDLE or DONE with start=1:
  - target <= value, a <= 0, b <= 1, k <= 0.
  - done <= 0; go to SEARCH.
- SEARCH, evaluated each edge, in priority order:
  - a == target: is_fib <= 1, n <= k, go to DONE.
  - a > target: is_fib <= 0, n <= k (index of the first Fibonacci number above value), go to DONE.
  - k == 47 and a < target: is_fib <= 0, n <= 48 (out-of-range marker), go to DONE.
  - Otherwise: a <= b[31:0], b <= a + b (33-bit sum), k <= k + 1.
- Value 1 matches at k=1, because the search takes the smallest matching index and never reaches k=2.
- b can exceed 32 bits only after k=46. It is never copied into a once k reaches 47, because termination takes priority.
- start is ignored in SEARCH. No queueing and no restart.
- DONE holds done, is_fib, n and prev_fib stable until the next start is accepted.
- Start accepted from DONE clears done on that same edge and enters SEARCH.
- Reset:
  - reset=0 on any edge forces IDLE.
  - Clears busy, done, is_fib, n, prev_fib, a, k and target to 0; b becomes 1.
  - Reset takes priority over start and over any SEARCH step, so a mid-search reset abandons the query.

## Timing
- Call the edge that accepts start E0. SEARCH evaluates F(k) on edge E(k+1).
- Latency from E0 to done=1 is K+1 cycles, where K is the terminating k.
  - Value 0: 1 cycle.
  - Worst case: 48 cycles.
- busy goes high the cycle after E0 and falls on the same edge that raises done.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The fastest back-to-back rate is one query per K+2 cycles: done is observed for one cycle, then start is accepted.

## Configuration
- FIB_INDEX_PREV_EN defined:
  - Adds the prev_fib output, registered on entry to DONE.
  - On a match, prev_fib = target.
  - Otherwise, prev_fib = the largest Fibonacci number ≤ value, i.e. F(k-1) on a>target exit and F(47) on the overflow exit.
  - Reset value is 0.
- FIB_INDEX_PREV_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset low 2 cycles, then start with value=0:
  - done rises 1 cycle after E0.
  - is_fib=1, n=0; with the macro, prev_fib=0.
- Value=1: is_fib=1, n=1, latency 2 cycles.
- Value=832040: is_fib=1, n=30, latency 31 cycles. busy is high for exactly 31 cycles.
- Value=100:
  - is_fib=0, n=12, latency 13; with the macro, prev_fib=89.
  - Then value=2971215073 issued from DONE: is_fib=1, n=47, latency 48.
- Value=32'hFFFFFFFF: is_fib=0, n=48, latency 48; with the macro, prev_fib=2971215073. No wrap or false match from the overflowed b.
- Start with value=832040, then hold start=1 and change value during SEARCH:
  - The changed value is ignored and the result is still n=30.
- Reset mid-search:
  - Drive reset=0 at k=10: on the next edge busy=0, done=0, n=0.
  - A subsequent start with value=5 gives n=5, is_fib=1.
